uart_msg_seq: RTL and testbench

UART_MSG_SEQ -- requirements
Module: uart_msg_seq

---
 rtl/uart_msg_seq.sv | 171 +++++++++++++++++
 tb/tb_uart_msg_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_seq.sv
// Message sequencer that stores MSG_NUM messages of up to MAX_LEN bytes and feeds them byte-wise to a UART TX.
// Optional macro UART_MSG_CRLF_APPEND_EN appends CR LF to every message pass.
module uart_msg_seq #(
    parameter int MSG_NUM = 4,
    parameter int MAX_LEN = 16,
    localparam int SW = $clog2(MSG_NUM),
    localparam int AW = $clog2(MAX_LEN),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_msg,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          len_we,
    input  logic [LW-1:0] len_data,
    input  logic          start,
    input  logic [SW-1:0] msg_sel,
    input  logic          loop_en,
    input  logic          abort,
    input  logic          tx_done,
    output logic [7:0]    data_tx,
    output logic          send_en,
    output logic          busy,
    output logic          msg_done
);

`ifdef UART_MSG_CRLF_APPEND_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, CR, LF} state_t;
    typedef enum logic [1:0] {T_DATA, T_CR, T_LF} tail_t;
    tail_t tail;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
`endif

    state_t        state;
    logic [SW-1:0] sel;
    logic [AW-1:0] idx;
    logic [7:0]    mem [MSG_NUM][MAX_LEN];
    logic [LW-1:0] len_q [MSG_NUM];
    logic [LW-1:0] cur_len;
    logic [LW:0]   idx_inc;
    logic          more_bytes;

    assign cur_len    = len_q[sel];
    assign idx_inc    = (LW+1)'(idx) + (LW+1)'(1);
    assign more_bytes = idx_inc < (LW+1)'(cur_len);

    // NOTE: the byte array has no reset so it maps onto plain RAM; only the lengths are cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && (32'(wr_msg) < MSG_NUM) && (32'(wr_addr) < MAX_LEN))
            mem[wr_msg][wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_NUM; i++) len_q[i] <= '0;
        end else if (len_we && !busy && (32'(wr_msg) < MSG_NUM)) begin
            len_q[wr_msg] <= (32'(len_data) > MAX_LEN) ? LW'(MAX_LEN) : len_data;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            idx      <= '0;
            data_tx  <= 8'h00;
            send_en  <= 1'b0;
            busy     <= 1'b0;
            msg_done <= 1'b0;
`ifdef UART_MSG_CRLF_APPEND_EN
            tail     <= T_DATA;
`endif
        end else begin
            send_en  <= 1'b0;
            msg_done <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            sel   <= msg_sel;
                            idx   <= '0;
                            busy  <= 1'b1;
                            state <= LOAD;
`ifndef UART_MSG_CRLF_APPEND_EN
                            // An empty message completes in the cycle right after acceptance.
                            if (len_q[msg_sel] == '0) msg_done <= 1'b1;
`endif
                        end
                    end
                    LOAD: begin
                        if (cur_len == '0) begin
`ifdef UART_MSG_CRLF_APPEND_EN
                            data_tx <= 8'h0D;
                            send_en <= 1'b1;
                            tail    <= T_CR;
                            state   <= SEND;
`else
                            // An empty message has nothing to repeat, so it never loops.
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end else begin
                            data_tx <= mem[sel][idx];
                            send_en <= 1'b1;
                            state   <= SEND;
`ifdef UART_MSG_CRLF_APPEND_EN
                            tail    <= T_DATA;
`endif
                        end
                    end
                    SEND: state <= WAIT;
                    WAIT: begin
                        if (tx_done) begin
`ifdef UART_MSG_CRLF_APPEND_EN
                            if (tail == T_LF) begin
                                msg_done <= 1'b1;
                                idx      <= '0;
                                state    <= loop_en ? LOAD : IDLE;
                                busy     <= loop_en;
                            end else if (tail == T_CR) begin
                                state <= LF;
                            end else if (more_bytes) begin
                                idx   <= idx + 1'b1;
                                state <= LOAD;
                            end else begin
                                state <= CR;
                            end
`else
                            if (more_bytes) begin
                                idx   <= idx + 1'b1;
                                state <= LOAD;
                            end else begin
                                msg_done <= 1'b1;
                                idx      <= '0;
                                state    <= loop_en ? LOAD : IDLE;
                                busy     <= loop_en;
                            end
`endif
                        end
                    end
`ifdef UART_MSG_CRLF_APPEND_EN
                    CR: begin
                        data_tx <= 8'h0D;
                        send_en <= 1'b1;
                        tail    <= T_CR;
                        state   <= SEND;
                    end
                    LF: begin
                        data_tx <= 8'h0A;
                        send_en <= 1'b1;
                        tail    <= T_LF;
                        state   <= SEND;
                    end
`endif
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_msg_seq.sv
// Self-checking bench for uart_msg_seq: table-driven message runs plus loop/abort, busy-guard, IDLE and reset sequences.
// Expected byte streams include CR LF when UART_MSG_CRLF_APPEND_EN is defined.
module tb_uart_msg_seq;
    localparam int MSG_NUM = 4;
    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_msg = '0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       len_we = 1'b0;
    logic [4:0] len_data = '0;
    logic       start = 1'b0;
    logic [1:0] msg_sel = '0;
    logic       loop_en = 1'b0;
    logic       abort = 1'b0;
    logic       tx_done;
    logic [7:0] data_tx;
    logic       send_en;
    logic       busy;
    logic       msg_done;

    logic uart_pulse = 1'b0;
    logic spur = 1'b0;
    assign tx_done = uart_pulse | spur;

    uart_msg_seq #(.MSG_NUM(MSG_NUM), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_msg(wr_msg), .wr_addr(wr_addr),
        .wr_data(wr_data), .len_we(len_we), .len_data(len_data), .start(start),
        .msg_sel(msg_sel), .loop_en(loop_en), .abort(abort), .tx_done(tx_done),
        .data_tx(data_tx), .send_en(send_en), .busy(busy), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sq_data [$];
    int         sq_cyc [$];
    int         done_cyc [$];
    always @(negedge clk) begin
        if (send_en) begin
            sq_data.push_back(data_tx);
            sq_cyc.push_back(cyc);
        end
        if (msg_done) done_cyc.push_back(cyc);
    end

    // UART TX stand-in: tx_done ten cycles after every send_en
    int cnt = 0;
    always @(negedge clk) begin
        uart_pulse = 1'b0;
        if (cnt == 1) uart_pulse = 1'b1;
        if (cnt != 0) cnt = cnt - 1;
        if (send_en) cnt = 10;
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] model [MSG_NUM][MAX_LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_byte(input int m, input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_msg = 2'(m); wr_addr = 4'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        model[m][a] = d;
    endtask

    task automatic wr_len(input int m, input int l);
        len_we = 1'b1; wr_msg = 2'(m); len_data = 5'(l);
        step();
        len_we = 1'b0;
    endtask

    task automatic run_msg(input string name, input int m, input int exp_len, input bit disturb);
        logic [7:0] exp [$];
        int b, d, n, g, last;
        for (int i = 0; i < exp_len; i++) exp.push_back(model[m][i]);
`ifdef UART_MSG_CRLF_APPEND_EN
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
`endif
        b = sq_data.size();
        d = done_cyc.size();
        msg_sel = 2'(m); start = 1'b1; n = cyc;
        step();
        start = 1'b0;
        if (disturb) begin
            wr_en = 1'b1; wr_msg = 2'(m); wr_addr = 4'd0; wr_data = 8'hFF;
            len_we = 1'b1; len_data = 5'd1;
            start = 1'b1; msg_sel = 2'(m + 1);
            step();
            wr_en = 1'b0; len_we = 1'b0; start = 1'b0;
        end
        g = 0;
        while (busy && g < 600) begin step(); g++; end
        check({name, "_finished"}, 32'(g < 600), 1);
        repeat (2) step();
        check({name, "_busy_fall"}, 32'(busy), 0);
        check({name, "_send_count"}, sq_data.size() - b, exp.size());
        last = n;
        for (int i = 0; i < exp.size() && b + i < sq_data.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(sq_data[b + i]), 32'(exp[i]));
            check($sformatf("%s_cyc%0d", name, i), sq_cyc[b + i], (i == 0) ? n + 2 : last + 12);
            last = sq_cyc[b + i];
        end
        check({name, "_done_count"}, done_cyc.size() - d, 1);
        if (done_cyc.size() > d)
            check({name, "_done_cyc"}, done_cyc[d], (exp.size() > 0) ? last + 11 : n + 1);
    endtask

    typedef struct {
        string name;
        int    msg;
        int    exp_len;
        bit    disturb;
    } vec_t;
    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int b, d, n, g, exp_done;
        logic [7:0] dt;
        logic [7:0] lexp [$];

        vecs[0] = '{"hello", 1, 5, 1'b0};
        vecs[1] = '{"saturate", 2, MAX_LEN, 1'b0};
        vecs[2] = '{"empty", 3, 0, 1'b0};
        vecs[3] = '{"busy_guard", 1, 5, 1'b1};
        vecs[4] = '{"hello_again", 1, 5, 1'b0};

        repeat (3) step();
        check("rst_data_tx", 32'(data_tx), 0);
        check("rst_send_en", 32'(send_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_msg_done", 32'(msg_done), 0);
        rst_n = 1'b1;
        step();

        s = "abc";
        for (int i = 0; i < 3; i++) wr_byte(0, i, s[i]);
        s = "hello";
        for (int i = 0; i < 5; i++) wr_byte(1, i, s[i]);
        for (int i = 0; i < MAX_LEN; i++) wr_byte(2, i, 8'(8'h10 + i));
        wr_byte(3, 0, 8'h55);
        wr_len(0, 3);
        wr_len(1, 5);
        wr_len(2, MAX_LEN + 3);
        wr_len(3, 0);

        for (int v = 0; v < 5; v++)
            run_msg(vecs[v].name, vecs[v].msg, vecs[v].exp_len, vecs[v].disturb);

        // Loop "abc" and abort after the fourth byte
        lexp = '{8'h61, 8'h62, 8'h63};
`ifdef UART_MSG_CRLF_APPEND_EN
        lexp.push_back(8'h0D);
        exp_done = 0;
`else
        lexp.push_back(8'h61);
        exp_done = 1;
`endif
        b = sq_data.size(); d = done_cyc.size();
        loop_en = 1'b1; msg_sel = 2'd0; start = 1'b1; n = cyc;
        step();
        start = 1'b0;
        g = 0;
        while (sq_data.size() - b < 4 && g < 300) begin step(); g++; end
        check("loop_reached_4", 32'(g < 300), 1);
        abort = 1'b1;
        step();
        abort = 1'b0; loop_en = 1'b0;
        check("loop_abort_busy", 32'(busy), 0);
        repeat (30) step();
        check("loop_send_count", sq_data.size() - b, 4);
        for (int i = 0; i < 4 && b + i < sq_data.size(); i++) begin
            check($sformatf("loop_byte%0d", i), 32'(sq_data[b + i]), 32'(lexp[i]));
            check($sformatf("loop_cyc%0d", i), sq_cyc[b + i], n + 2 + 12 * i);
        end
        check("loop_done_count", done_cyc.size() - d, exp_done);
        if (exp_done == 1 && done_cyc.size() > d)
            check("loop_done_cyc", done_cyc[d], n + 37);

        // Spurious tx_done in IDLE
        b = sq_data.size(); d = done_cyc.size(); dt = data_tx;
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (3) step();
        check("spur_no_send", sq_data.size() - b, 0);
        check("spur_busy", 32'(busy), 0);
        check("spur_data_tx", 32'(data_tx), 32'(dt));
        check("spur_no_done", done_cyc.size() - d, 0);

        // abort beats start in the same cycle
        b = sq_data.size();
        start = 1'b1; abort = 1'b1; msg_sel = 2'd1;
        step();
        start = 1'b0; abort = 1'b0;
        repeat (3) step();
        check("abort_start_busy", 32'(busy), 0);
        check("abort_start_no_send", sq_data.size() - b, 0);

        // Reset while waiting for tx_done
        b = sq_data.size();
        msg_sel = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        g = 0;
        while (sq_data.size() == b && g < 50) begin step(); g++; end
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_data_tx", 32'(data_tx), 0);
        check("midrst_send_en", 32'(send_en), 0);
        check("midrst_msg_done", 32'(msg_done), 0);
        step();
        rst_n = 1'b1;
        repeat (40) step();
        check("midrst_send_count", sq_data.size() - b, 1);
        run_msg("after_rst_len0", 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
